// File: rtl/fsm_mon_pkg.sv
// ============================================================================
// fsm_mon_pkg : shared encodings, monitor states and helpers for the
//               one-hot sequencer monitor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fsm_mon_pkg;

  localparam logic [3:0] S0 = 4'b0001;
  localparam logic [3:0] S1 = 4'b0010;
  localparam logic [3:0] S2 = 4'b0100;
  localparam logic [3:0] S3 = 4'b1000;

  typedef enum logic [1:0] {
    MON_SYNC  = 2'd0,
    MON_TRACK = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v == S0) || (v == S1) || (v == S2) || (v == S3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_next_predict.sv
// ============================================================================
// onehot_next_predict : combinational model of the sequencer next-state
//                       function, used to predict the following sample.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module onehot_next_predict
  import fsm_mon_pkg::*;
(
  input  logic [3:0] prev_state,
  input  logic       cond_a,
  input  logic       cond_b,
  output logic [3:0] exp_state
);

  always_comb begin
    exp_state = S0;
    case (prev_state)
      S0:      exp_state = cond_a ? S1 : S0;
      S1:      exp_state = cond_b ? S2 : S0;
      S2:      exp_state = S3;
      S3:      exp_state = S0;
      default: exp_state = S0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/onehot_fsm_monitor.sv
// ============================================================================
// onehot_fsm_monitor : watches a 4-state one-hot sequencer bus, flags illegal
//                      encodings/transitions, counts faults, requests recovery.
//                      Transition checking built only with FSM_MON_TRANS_CHECK_EN.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module onehot_fsm_monitor
  import fsm_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       state_i,
  input  logic             cond_a,
  input  logic             cond_b,
  input  logic             recover_ack,
  output logic             err_encoding,
  output logic             err_transition,
  output logic             recover_req,
  output logic [3:0]       bad_state,
  output logic [CNT_W-1:0] err_count
);

  mon_state_t       r_state;
  mon_state_t       w_state_nxt;
  logic             r_err_enc;
  logic             r_err_trans;
  logic [3:0]       r_bad_state;
  logic [CNT_W-1:0] r_err_count;

  logic             w_enc_err;
  logic             w_trans_err;
  logic             w_any_err;

  assign w_enc_err = !is_onehot4(state_i);

`ifdef FSM_MON_TRANS_CHECK_EN
  logic [3:0] r_prev;
  logic       r_cond_a;
  logic       r_cond_b;
  logic [3:0] w_expected;

  onehot_next_predict u_predict (
    .prev_state (r_prev),
    .cond_a     (r_cond_a),
    .cond_b     (r_cond_b),
    .exp_state  (w_expected)
  );

  // The previous sample is recorded every cycle, so a fault or resync never
  // leaves a stale prediction behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev   <= 4'b0000;
      r_cond_a <= 1'b0;
      r_cond_b <= 1'b0;
    end else begin
      r_prev   <= state_i;
      r_cond_a <= cond_a;
      r_cond_b <= cond_b;
    end
  end

  assign w_trans_err = (r_state != MON_SYNC) && !w_enc_err && (state_i != w_expected);
`else
  logic w_unused_conds;
  assign w_unused_conds = cond_a ^ cond_b;
  assign w_trans_err    = 1'b0;
`endif

  assign w_any_err = w_enc_err || w_trans_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MON_SYNC:  w_state_nxt = w_any_err ? MON_FAULT : MON_TRACK;
      MON_TRACK: w_state_nxt = w_any_err ? MON_FAULT : MON_TRACK;
      MON_FAULT: w_state_nxt = (recover_ack && !w_any_err) ? MON_SYNC : MON_FAULT;
      default:   w_state_nxt = MON_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= MON_SYNC;
      r_err_enc   <= 1'b0;
      r_err_trans <= 1'b0;
      r_bad_state <= 4'b0000;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_err_enc   <= w_enc_err;
      r_err_trans <= w_trans_err;
      // Freeze the offending value once faulted so the controller sees the root cause.
      if ((r_state != MON_FAULT) && (w_state_nxt == MON_FAULT)) begin
        r_bad_state <= state_i;
      end
      if (w_any_err && !(&r_err_count)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign err_encoding   = r_err_enc;
  assign err_transition = r_err_trans;
  assign recover_req    = (r_state == MON_FAULT);
  assign bad_state      = r_bad_state;
  assign err_count      = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_onehot_fsm_monitor.sv
// ============================================================================
// tb_onehot_fsm_monitor : directed self-checking bench; a second instance with
//                         CNT_W=2 shares the stimulus to exercise saturation.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_onehot_fsm_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] state_i;
  logic       cond_a;
  logic       cond_b;
  logic       recover_ack;

  logic       err_encoding,   err_encoding2;
  logic       err_transition, err_transition2;
  logic       recover_req,    recover_req2;
  logic [3:0] bad_state,      bad_state2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int n_checks;
  int n_fail;
  int base_cnt;

  onehot_fsm_monitor #(.CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .state_i        (state_i),
    .cond_a         (cond_a),
    .cond_b         (cond_b),
    .recover_ack    (recover_ack),
    .err_encoding   (err_encoding),
    .err_transition (err_transition),
    .recover_req    (recover_req),
    .bad_state      (bad_state),
    .err_count      (err_count)
  );

  onehot_fsm_monitor #(.CNT_W(2)) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .state_i        (state_i),
    .cond_a         (cond_a),
    .cond_b         (cond_b),
    .recover_ack    (recover_ack),
    .err_encoding   (err_encoding2),
    .err_transition (err_transition2),
    .recover_req    (recover_req2),
    .bad_state      (bad_state2),
    .err_count      (err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample, let the edge take it, then look 1ns after the edge.
  task automatic cycle(input logic [3:0] s, input logic a, input logic b, input logic ack);
    state_i     = s;
    cond_a      = a;
    cond_b      = b;
    recover_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic enc, input logic trn,
                           input logic req, input logic [3:0] bad, input int cnt);
    check({tag, ".enc"}, {31'd0, err_encoding}, {31'd0, enc});
    check({tag, ".trn"}, {31'd0, err_transition}, {31'd0, trn});
    check({tag, ".req"}, {31'd0, recover_req}, {31'd0, req});
    check({tag, ".bad"}, {28'd0, bad_state}, {28'd0, bad});
    check({tag, ".cnt"}, {24'd0, err_count}, cnt);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    state_i     = 4'b0001;
    cond_a      = 1'b0;
    cond_b      = 1'b0;
    recover_ack = 1'b0;

    #12;
    check_all("reset", 1'b0, 1'b0, 1'b0, 4'b0000, 0);
    check("reset.sat_cnt", {30'd0, err_count2}, 32'd0);
    reset = 1'b0;

    // Legal walk S0 -> S1 -> S2 -> S3 -> S0
    cycle(4'b0001, 1'b1, 1'b0, 1'b0); check_all("legal0", 1'b0, 1'b0, 1'b0, 4'b0000, 0);
    cycle(4'b0010, 1'b0, 1'b1, 1'b0); check_all("legal1", 1'b0, 1'b0, 1'b0, 4'b0000, 0);
    cycle(4'b0100, 1'b0, 1'b0, 1'b0); check_all("legal2", 1'b0, 1'b0, 1'b0, 4'b0000, 0);
    cycle(4'b1000, 1'b0, 1'b0, 1'b0); check_all("legal3", 1'b0, 1'b0, 1'b0, 4'b0000, 0);
    cycle(4'b0001, 1'b0, 1'b0, 1'b0); check_all("legal4", 1'b0, 1'b0, 1'b0, 4'b0000, 0);

    // Multi-hot encoding while tracking
    cycle(4'b0110, 1'b0, 1'b0, 1'b0); check_all("enc_err", 1'b1, 1'b0, 1'b1, 4'b0110, 1);
    check("enc_err.sat_cnt", {30'd0, err_count2}, 32'd1);
    // Illegal P predicts S0, so a clean S0 in fault raises nothing new
    cycle(4'b0001, 1'b0, 1'b0, 1'b0); check_all("enc_hold", 1'b0, 1'b0, 1'b1, 4'b0110, 1);

    // Ack collides with a fresh 0000 sample: error wins
    cycle(4'b0000, 1'b0, 1'b0, 1'b1); check_all("ack_coll", 1'b1, 1'b0, 1'b1, 4'b0110, 2);
    // Clean ack: P=0000 predicts S0
    cycle(4'b0001, 1'b0, 1'b0, 1'b1); check_all("ack_clean", 1'b0, 1'b0, 1'b0, 4'b0110, 2);
    // Resync sample, establishes P=S0 with cond_a=0
    cycle(4'b0001, 1'b0, 1'b0, 1'b0); check_all("resync", 1'b0, 1'b0, 1'b0, 4'b0110, 2);

    // Skipped state: S0 with cond_a=0 jumps to S2
    cycle(4'b0100, 1'b0, 1'b0, 1'b0);
`ifdef FSM_MON_TRANS_CHECK_EN
    check_all("skip", 1'b0, 1'b1, 1'b1, 4'b0100, 3);
    base_cnt = 3;
`else
    check_all("skip", 1'b0, 1'b0, 1'b0, 4'b0110, 2);
    base_cnt = 2;
`endif

    // Five consecutive bad encodings
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    cycle(4'b0101, 1'b0, 1'b0, 1'b0);
`ifdef FSM_MON_TRANS_CHECK_EN
    check_all("burst", 1'b1, 1'b0, 1'b1, 4'b0100, base_cnt + 5);
`else
    check_all("burst", 1'b1, 1'b0, 1'b1, 4'b0000, base_cnt + 5);
`endif
    check("burst.sat_cnt", {30'd0, err_count2}, 32'd3);
    check("burst.sat_req", {31'd0, recover_req2}, 32'd1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 4'b0000, 0);
    check("async_rst.sat_cnt", {30'd0, err_count2}, 32'd0);
    check("async_rst.sat_bad", {28'd0, bad_state2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // First sample after release is a sync sample: no transition check
    cycle(4'b1000, 1'b0, 1'b0, 1'b0); check_all("post_rst0", 1'b0, 1'b0, 1'b0, 4'b0000, 0);
    cycle(4'b0001, 1'b0, 1'b0, 1'b0); check_all("post_rst1", 1'b0, 1'b0, 1'b0, 4'b0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
